// File: rtl/gpio_controller.sv
// gpio_controller: memory-mapped GPIO peripheral.
// The register window holds OUT, DIR, IN, RISE_EN, FALL_EN and PENDING.
// Each pin has a two-flop input synchroniser. Edges are detected on the
// synchronised value and latched into a write-1-to-clear PENDING register,
// and irq is the OR of PENDING.
// Optional feature: define GPIO_DEBOUNCE_EN to add a per-pin stable-count
// debounce between the synchroniser and IN.
module gpio_controller #(
   parameter int WIDTH           = 16,
   parameter int ADDR_W          = 5,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   inout  wire  [WIDTH-1:0]  gpioPorts,
   output logic              irq
);

   localparam int OFF_W = ADDR_W - 2;
   localparam logic [OFF_W-1:0] OFF_OUT     = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_DIR     = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_IN      = OFF_W'(2);
   localparam logic [OFF_W-1:0] OFF_RISE_EN = OFF_W'(3);
   localparam logic [OFF_W-1:0] OFF_FALL_EN = OFF_W'(4);
   localparam logic [OFF_W-1:0] OFF_PENDING = OFF_W'(5);

   logic [OFF_W-1:0] offset;
   logic [WIDTH-1:0] wval;
   logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
   logic [WIDTH-1:0] in_val, evt, clr, rd_val;
   logic             unused_bits;

   assign offset = addr[ADDR_W-1:2];
   assign wval   = wdata[WIDTH-1:0];
   // The byte-lane bits and any write-data bits above WIDTH carry no meaning here.
   assign unused_bits = ^{addr[1:0], wdata, (DEBOUNCE_CYCLES > 0)};

   // Pin drivers: a pin is driven only while its DIR bit is set.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign gpioPorts[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            in_q, in_d;

   // Debounce: IN follows s2 only after DEBOUNCE_CYCLES consecutive differing cycles.
   always_comb begin
      cnt_d = cnt_q;
      in_d  = in_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2_q[i] == in_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            in_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         in_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         in_q  <= in_d;
      end
   end

   assign in_val = in_q;
`else
   assign in_val = s2_q;
`endif

   // Register writes, synchroniser shift and edge detection.
   always_comb begin
      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (we) begin
         case (offset)
            OFF_OUT:     out_d     = wval;
            OFF_DIR:     dir_d     = wval;
            OFF_RISE_EN: rise_en_d = wval;
            OFF_FALL_EN: fall_en_d = wval;
            OFF_PENDING: clr       = wval;
            default:     ;
         endcase
      end
      s1_d   = gpioPorts;
      s2_d   = s1_q;
      prev_d = in_val;
      // The event uses the enables already in force this cycle, so an enable
      // written now cannot fire on a transition that has already happened.
      evt       = (in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q);
      // Set wins over a simultaneous clear of the same bit.
      pending_d = (pending_q & ~clr) | evt;
   end

   // State registers.
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         pending_q <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         prev_q    <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         pending_q <= pending_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         prev_q    <= prev_d;
      end
   end

   // Combinational read mux; unmapped offsets read as zero.
   always_comb begin
      rd_val = '0;
      case (offset)
         OFF_OUT:     rd_val = out_q;
         OFF_DIR:     rd_val = dir_q;
         OFF_IN:      rd_val = in_val;
         OFF_RISE_EN: rd_val = rise_en_q;
         OFF_FALL_EN: rd_val = fall_en_q;
         OFF_PENDING: rd_val = pending_q;
         default:     rd_val = '0;
      endcase
   end

   assign rdata = 32'(rd_val);
   assign irq   = |pending_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed, table-driven bench for gpio_controller (WIDTH = 16).
module tb_gpio_controller;

`ifdef GPIO_DEBOUNCE_EN
   localparam int L = 2 + 4;
`else
   localparam int L = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   wire  [15:0] gpio_pins;
   logic [15:0] ext_en;
   logic [15:0] ext_val;
   int          total = 0;
   int          bad   = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [15:0] ext_val;
      int          cycles;
      logic [4:0]  raddr;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   for (genvar g = 0; g < 16; g++) begin : g_ext
      assign gpio_pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
   end

   gpio_controller #(.WIDTH(16), .ADDR_W(5), .DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .we        (we),
      .wdata     (wdata),
      .rdata     (rdata),
      .gpioPorts (gpio_pins),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      ext_en  = 16'hFFFF;
      ext_val = 16'h0000;

      // Reset state: every offset reads zero and irq is low.
      #2;
      for (int a = 0; a < 8; a++) begin
         addr = 5'(a * 4);
         #1;
         check($sformatf("reset_rd_%0h", a * 4), rdata, 32'h0);
      end
      check("reset_irq", {31'b0, irq}, 32'h0);

      @(negedge clk);
      reset   = 1'b0;
      ext_en  = 16'hFF00;
      ext_val = 16'h3C00;

      vecs.push_back('{"dir_wr",       1'b1, 5'h04, 32'h00FF, 16'h3C00, 1,   5'h04, 32'h00FF, 1'b0});
      vecs.push_back('{"out_wr",       1'b1, 5'h00, 32'hA5A5, 16'h3C00, 1,   5'h00, 32'hA5A5, 1'b0});
      vecs.push_back('{"in_read",      1'b0, 5'h00, 32'h0,    16'h3C00, L,   5'h08, 32'h3CA5, 1'b0});
      vecs.push_back('{"in_wr_ignore", 1'b1, 5'h08, 32'hFFFF, 16'h3C00, 1,   5'h08, 32'h3CA5, 1'b0});
      vecs.push_back('{"unmapped_18",  1'b1, 5'h18, 32'hFFFF, 16'h3C00, 1,   5'h18, 32'h0,    1'b0});
      vecs.push_back('{"unmapped_1c",  1'b0, 5'h00, 32'h0,    16'h3C00, 1,   5'h1C, 32'h0,    1'b0});
      vecs.push_back('{"rise_en_wr",   1'b1, 5'h0C, 32'h0100, 16'h3C00, 1,   5'h0C, 32'h0100, 1'b0});
      vecs.push_back('{"rise_wait",    1'b0, 5'h00, 32'h0,    16'h3D00, L,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"rise_pend",    1'b0, 5'h00, 32'h0,    16'h3D00, 1,   5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"fall_no_evt",  1'b0, 5'h00, 32'h0,    16'h3C00, L+2, 5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"rise_again",   1'b0, 5'h00, 32'h0,    16'h3D00, L,   5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"clr_and_set",  1'b1, 5'h14, 32'h0100, 16'h3D00, 1,   5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"clr_plain",    1'b1, 5'h14, 32'h0100, 16'h3D00, 1,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"clr_not_pend", 1'b1, 5'h14, 32'hFFFF, 16'h3D00, 1,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"fall_en_wr",   1'b1, 5'h10, 32'h0100, 16'h3D00, 1,   5'h10, 32'h0100, 1'b0});
      vecs.push_back('{"fall_pend",    1'b0, 5'h00, 32'h0,    16'h3C00, L+1, 5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"fall_en_off",  1'b1, 5'h10, 32'h0,    16'h3C00, 1,   5'h14, 32'h0100, 1'b1});
      vecs.push_back('{"pend_clr",     1'b1, 5'h14, 32'h0100, 16'h3C00, 1,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"pin9_up",      1'b0, 5'h00, 32'h0,    16'h3E00, L,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"en_late",      1'b1, 5'h0C, 32'h0200, 16'h3E00, 1,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"no_spurious",  1'b0, 5'h00, 32'h0,    16'h3E00, 3,   5'h14, 32'h0,    1'b0});
      vecs.push_back('{"in_final",     1'b0, 5'h00, 32'h0,    16'h3E00, 1,   5'h08, 32'h3EA5, 1'b0});

      foreach (vecs[k]) begin
         ext_val = vecs[k].ext_val;
         we      = vecs[k].we;
         addr    = vecs[k].addr;
         wdata   = vecs[k].wdata;
         tick();
         we = 1'b0;
         repeat (vecs[k].cycles - 1) tick();
         addr = vecs[k].raddr;
         #1;
         check(vecs[k].name, rdata, vecs[k].exp_rdata);
         check({vecs[k].name, "_irq"}, {31'b0, irq}, {31'b0, vecs[k].exp_irq});
      end

      // Low byte is driven from OUT.
      check("pins_low_byte", {24'b0, gpio_pins[7:0]}, 32'h00A5);

      // Build a pending rise on pin 9, then reset in the middle of a write.
      ext_val = 16'h3C00;
      repeat (L + 1) tick();
      ext_val = 16'h3E00;
      repeat (L + 1) tick();
      addr = 5'h14;
      #1;
      check("pre_reset_pend", rdata, 32'h0200);
      check("pre_reset_irq", {31'b0, irq}, 32'h1);

      we    = 1'b1;
      addr  = 5'h00;
      wdata = 32'hFFFF;
      #1;
      reset = 1'b1;
      #1;
      we = 1'b0;
      for (int a = 0; a < 6; a++) begin
         addr = 5'(a * 4);
         #1;
         check($sformatf("midrst_rd_%0h", a * 4), rdata, 32'h0);
      end
      check("midrst_irq", {31'b0, irq}, 32'h0);

      // Pin 9 held high through reset: prev restarts at 0, so a rise follows.
      ext_en  = 16'hFFFF;
      ext_val = 16'h3E00;
      @(negedge clk);
      reset = 1'b0;
      we    = 1'b1;
      addr  = 5'h0C;
      wdata = 32'h0200;
      tick();
      we   = 1'b0;
      addr = 5'h14;
      repeat (L - 1) tick();
      check("post_rst_wait", rdata, 32'h0);
      tick();
      check("post_rst_rise", rdata, 32'h0200);
      check("post_rst_irq", {31'b0, irq}, 32'h1);

`ifdef GPIO_DEBOUNCE_EN
      addr    = 5'h08;
      ext_val = 16'h3C00;
      repeat (10) tick();
      check("db_settle", {31'b0, rdata[9]}, 32'h0);
      ext_val = 16'h3E00;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("db_short_hi_%0d", c), {31'b0, rdata[9]}, 32'h0);
      end
      ext_val = 16'h3C00;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("db_short_lo_%0d", c), {31'b0, rdata[9]}, 32'h0);
      end
      ext_val = 16'h3E00;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check($sformatf("db_long_%0d", c), {31'b0, rdata[9]}, (c == 6) ? 32'h1 : 32'h0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gpio_controller.md
Name: gpio_controller

Overview:
- Memory-mapped, parametrised GPIO peripheral. Successor to the fixed 16-pin GPIO in the top level.
- Sits on the CPU data bus beside data memory and drives the top-level bidirectional `gpioPorts` pins.
- Adds per-pin direction control, input synchronisation, rising/falling edge detection, a write-1-to-clear pending register and a single interrupt output.

Parameters:
- WIDTH, 16, number of GPIO pins (1..32).
- ADDR_W, 5, byte-address width of the register window.
- DEBOUNCE_CYCLES, 4, stable-cycle count for debounce; used only with GPIO_DEBOUNCE_EN, must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  byte address; bits [1:0] ignored.
- we  in  1  write strobe; full-word write on rising edge.
- wdata  in  32  write data; only bits [WIDTH-1:0] are used.
- rdata  out  32  combinational read data; upper bits are zero-extended.
- gpioPorts  inout  WIDTH  pins.
- irq  out  1  interrupt; equals OR of PENDING.

Behaviour:
- Register map (word offsets):
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write; 1 = output.
  - 0x08 IN: read-only.
  - 0x0C RISE_EN: read/write.
  - 0x10 FALL_EN: read/write.
  - 0x14 PENDING: read; write-1-to-clear.
- Unmapped offsets (0x18..0x1C): read 0, writes ignored. Writes to IN are ignored.
- Reset (asynchronous, immediate): OUT, DIR, RISE_EN, FALL_EN, PENDING, sync and prev registers all go to 0.
  - All pins are Hi-Z and irq = 0.
  - rdata reflects the register map, e.g. 0 for every register except IN.
- Pin drive: gpioPorts[i] = DIR[i] ? OUT[i] : 1'bz.
  - A DIR or OUT write takes effect on the pin immediately after the write edge.
- Input path: two-flop synchroniser s1 -> s2 per pin.
  - IN = s2, so a pin change is visible in IN after the 2nd rising edge.
  - Pins configured as outputs are still sampled; IN reads back the driven value.
- Edge detect: prev <= IN every cycle.
  - rise[i] = IN[i] & ~prev[i] & RISE_EN[i]
  - fall[i] = ~IN[i] & prev[i] & FALL_EN[i]
  - An event sets PENDING[i] on the next edge, i.e. the 3rd rising edge after the pin change.
  - irq is combinational from PENDING, with no extra delay.
- PENDING update per bit, each cycle: PENDING <= (PENDING & ~clr) | event, where clr = wdata when (we && offset 0x14), else 0.
  - A simultaneous event and clear on the same bit leaves the bit set (set wins).
  - Clearing bits not pending has no effect.
- Enable changes: clearing RISE_EN/FALL_EN does not clear already-pending bits.
  - Enabling while prev != IN does not create a spurious event; the event depends only on the current-cycle transition.
- Reset mid-operation: synchroniser history is lost.
  - The first cycles after reset compare against prev = 0, so a pin held high produces a rise event once IN becomes 1, if RISE_EN is set by then.
- Glitches shorter than one clock may be missed; this is acceptable.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - A per-pin counter, width clog2(DEBOUNCE_CYCLES+1), follows s2.
  - IN[i] updates only after s2[i] differs from IN[i] for DEBOUNCE_CYCLES consecutive cycles.
  - The counter resets to 0 whenever s2[i] == IN[i].
  - Input latency becomes 2 + DEBOUNCE_CYCLES edges; edge detection operates on the debounced IN.
  - Counters reset to 0.
- Undefined: no counters; IN = s2 directly.

Test Plan:
- Reset with pins pulled externally to 0x0000 -> rdata = 0 at all offsets, irq = 0, gpioPorts all Z.
- Write DIR = 0x00FF, OUT = 0xA5A5 -> gpioPorts[7:0] = 0xA5, upper byte Z; IN reads 0x??A5 after 2 edges, with the upper byte following the external drive.
- RISE_EN = 0x0100; drive pin 8 low->high -> PENDING = 0x0100 and irq = 1 exactly 3 edges after the change; pin 8 high->low with FALL_EN = 0 -> no new event.
- Write 0x0100 to PENDING in the same cycle as a new rise event on pin 8 -> PENDING stays 0x0100; a plain write of 0x0100 next cycle -> PENDING = 0, irq = 0.
- Read offset 0x18 -> 0; write offset 0x08 with 0xFFFF -> IN unchanged; assert reset mid-write -> all registers 0 immediately.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4: a 3-cycle pulse on pin 9 -> IN[9] never changes; a 6-cycle pulse -> IN[9] = 1 at edge 6 after the rise.
